// File: rtl/hilo_md_unit_if.sv
// Interface bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             En;
  logic [2:0]       Op;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] AluResult;
  logic [WIDTH-1:0] AluResult2;
  logic             RdHiLo;
  logic             Flush;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Stall;
  logic             Done;

  modport master (
    output En, Op, X, Y, AluResult, AluResult2, RdHiLo, Flush,
    input  Hi, Lo, Busy, Stall, Done
  );

  modport slave (
    input  En, Op, X, Y, AluResult, AluResult2, RdHiLo, Flush,
    output Hi, Lo, Busy, Stall, Done
  );
endinterface

// File: rtl/hilo_md_unit.sv
// HI/LO register owner: MULT capture, MTHI/MTLO, iterative restoring divider.
// Optional signed DIV (Op 101) is built only when SIGNED_DIV_EN is defined.
module hilo_md_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  hilo_md_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_MULT = 3'b001,
    OP_DIVU = 3'b010,
    OP_MTHI = 3'b011,
    OP_MTLO = 3'b100,
    OP_DIV  = 3'b101
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  op_e              op;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [WIDTH-1:0] rem_q, quot_q, dvs_q;
  logic [WIDTH-1:0] rem_n, quot_n;
  logic [WIDTH-1:0] dvd_ld, dvs_ld;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   trial;
  logic [CW-1:0]    cnt_q;
  logic             done_q;
  logic             busy, accept, is_div, op_valid, last;
  logic             load, step, commit;
`ifdef SIGNED_DIV_EN
  logic             qneg_q, rneg_q, qneg_ld, rneg_ld;
`endif

  assign op     = op_e'(bus.Op);
  assign busy   = (state_q == RUN);
  assign accept = bus.En & ~busy & ~bus.Flush;
  assign last   = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    op_valid = 1'b0;
    is_div   = 1'b0;
    case (op)
      OP_MULT, OP_MTHI, OP_MTLO: op_valid = 1'b1;
      OP_DIVU: begin
        op_valid = 1'b1;
        is_div   = 1'b1;
      end
`ifdef SIGNED_DIV_EN
      OP_DIV: begin
        op_valid = 1'b1;
        is_div   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Stall deliberately ignores Flush so it stays off the exception path.
  assign bus.Stall = busy & ((bus.En & op_valid) | bus.RdHiLo);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_div) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (bus.Flush) begin
          state_d = IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trial  = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_n  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
    quot_n = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_comb begin
    dvd_ld  = bus.X;
    dvs_ld  = bus.Y;
`ifdef SIGNED_DIV_EN
    qneg_ld = 1'b0;
    rneg_ld = 1'b0;
    if (op == OP_DIV) begin
      dvd_ld  = bus.X[WIDTH-1] ? -bus.X : bus.X;
      dvs_ld  = bus.Y[WIDTH-1] ? -bus.Y : bus.Y;
      qneg_ld = bus.X[WIDTH-1] ^ bus.Y[WIDTH-1];
      rneg_ld = bus.X[WIDTH-1];
    end
`endif
  end

  // Sign fix-up in the commit cycle; a zero divisor keeps the all-ones quotient
  // and the negated remainder magnitude restores the original dividend.
  always_comb begin
`ifdef SIGNED_DIV_EN
    q_fix = (qneg_q && (dvs_q != '0)) ? -quot_n : quot_n;
    r_fix = rneg_q ? -rem_n : rem_n;
`else
    q_fix = quot_n;
    r_fix = rem_n;
`endif
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      lo_d = q_fix;
      hi_d = r_fix;
    end else if (accept) begin
      case (op)
        OP_MULT: begin
          lo_d = bus.AluResult;
          hi_d = bus.AluResult2;
        end
        OP_MTHI: hi_d = bus.X;
        OP_MTLO: lo_d = bus.X;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= commit;
      if (load) begin
        rem_q  <= '0;
        quot_q <= dvd_ld;
        dvs_q  <= dvs_ld;
        cnt_q  <= '0;
`ifdef SIGNED_DIV_EN
        qneg_q <= qneg_ld;
        rneg_q <= rneg_ld;
`endif
      end else if (step) begin
        rem_q  <= rem_n;
        quot_q <= quot_n;
        cnt_q  <= cnt_q + CW'(1);
      end
    end
  end

  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;
  assign bus.Busy = busy;
  assign bus.Done = done_q;

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Downstream consumer of the EX-stage ALU's multiply path; owns the architectural HI/LO registers.
- MULT: captures the ALU's single-cycle product, Result into LO and Result2 into HI.
- DIV: replaced by an iterative restoring divider, one quotient bit per cycle, which stalls the pipeline while busy.
- Sources MFHI/MFLO data to the writeback mux.

Parameters:
- WIDTH, 32, operand/HI/LO width; divide latency is WIDTH cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- En  in  1  EX-stage instruction valid and not squashed
- Op  in  3  000 none, 001 MULT, 010 DIVU, 011 MTHI, 100 MTLO, 101 DIV (signed, see Optional Feature), others none
- X  in  WIDTH  rs operand: dividend, or MTHI/MTLO source
- Y  in  WIDTH  rt operand: divisor
- AluResult  in  WIDTH  ALU low product word
- AluResult2  in  WIDTH  ALU high product word
- RdHiLo  in  1  MFHI/MFLO present in EX
- Flush  in  1  squash in-progress divide (exception/redirect)
- Hi  out  WIDTH  HI register
- Lo  out  WIDTH  LO register
- Busy  out  1  divide in progress
- Stall  out  1  hold pipeline
- Done  out  1  one-cycle pulse: divide committed

Behaviour:
- Reset: asynchronous on rst_n=0. Hi=0, Lo=0, Busy=0, Done=0, divider state cleared. A reset during a divide aborts it with no commit.
- Accept condition: En=1, Busy=0, Flush=0. Operations are evaluated at the rising edge.
- MULT: Lo<=AluResult, Hi<=AluResult2 at the accepting edge.
- MTHI: Hi<=X. MTLO: Lo<=X. Both at the accepting edge.
- Op none: no state change.
- States:
  - IDLE: on an accepted DIVU/DIV, latch X, Y, clear remainder and count, go to RUN. Busy=1 from the next cycle.
  - RUN: per cycle, shift {rem,quot} left 1, trial-subtract divisor, set quotient bit if no borrow, increment count.
  - RUN, on the WIDTH-th iteration edge: Lo<=quotient, Hi<=remainder, Busy->0, Done=1 for the following cycle, return to IDLE.
- Timing: accept at edge E0; Busy high for exactly WIDTH cycles; Hi/Lo valid after edge E0+WIDTH.
- Divisor zero: Lo<=all ones, Hi<=X (the natural restoring result). Full latency still applies.
- Stall = Busy & ((En & Op!=none) | RdHiLo).
  - Operations presented while busy are not accepted; the pipeline re-presents them after Busy falls.
  - Stall is combinational. It must not depend on Flush.
- Flush:
  - With Busy=1: abort. Busy->0 at the next edge, Hi/Lo unchanged, no Done.
  - With an operation accepted in the same cycle: Flush wins, and the operation is dropped.
- Simultaneous final divide iteration and Flush: Flush wins; no commit.
- Hi/Lo change only on an accepted operation or a divide commit. Reads are direct register outputs, no bypass.

Optional Feature:
- Macro: SIGNED_DIV_EN
- Defined: Op 101 (DIV) is accepted.
  - The divider runs on the magnitudes of X and Y.
  - The quotient is negated when the signs of X and Y differ.
  - The remainder takes the sign of X.
  - -2^31 / -1 gives Lo=0x80000000, Hi=0.
  - Divisor zero gives Lo=all ones, Hi=X.
  - Latency is unchanged at WIDTH cycles; sign fix-up happens in the commit cycle.
- Undefined: Op 101 is treated as none (no state change, no Stall contribution). The sign logic is not synthesized.

Test Plan:
- Reset: assert rst_n=0 mid-cycle, after preloading Hi/Lo=0x1234 via MTHI/MTLO -> Hi=Lo=0, Busy=0, Done=0 immediately (asynchronous).
- MULT: AluResult=0xDEADBEEF, AluResult2=0x00000001, En=1, Op=001 -> next cycle Lo=0xDEADBEEF, Hi=0x00000001, Busy stays 0.
- DIVU: X=100, Y=7 -> Busy high exactly 32 cycles, Lo=14, Hi=2, Done pulses once. DIVU X=5, Y=0 -> Lo=0xFFFFFFFF, Hi=5.
- Stall: start DIVU, then hold RdHiLo=1 and present MTLO X=9 during the busy window.
  - Stall=1 every busy cycle; Hi/Lo hold the old values.
  - MTLO accepted only after Busy falls, giving Lo=9.
- Flush: Flush=1 at cycle 10 of a DIVU with old Hi/Lo=3/4 -> Busy=0 next cycle, Hi=3, Lo=4, no Done.
- Signed (SIGNED_DIV_EN defined):
  - X=-7, Y=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - X=0x80000000, Y=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
  - With the macro undefined, Op=101 -> no change, Stall=0.
